regfile_sb: RTL and testbench

- Parametrised successor to the pipeline CPU's 32x32 register file: 2 async read ports, 1 write port, with a per-register pending-write scoreboard.
- Sits between ID and WB stages. ID reads operands and marks destinations pending at issue. WB writes results and clears pending.
- Adds synchronous reset of contents, a configurable hard-wired zero register, optional write-to-read bypass, and hazard/stall outputs for the hazard unit.

---
 rtl/regfile_sb_pkg.sv | 6 +
 rtl/regfile_sb_sb_bits.sv | 47 ++++
 rtl/regfile_sb.sv | 79 +++++++
 tb/tb_regfile_sb.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_sb_pkg.sv
// Shared defaults and constants for the scoreboarded register file.
package regfile_sb_pkg;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned REG_ZERO   = 0;
endpackage

// File: rtl/regfile_sb_sb_bits.sv
// Pending-write scoreboard: one bit per register plus a running pending count.
module sb_bits
  import regfile_sb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      set_en,
  input  logic [ADDR_W-1:0]         set_idx,
  input  logic                      clr_en,
  input  logic [ADDR_W-1:0]         clr_idx,
  output logic [(1 << ADDR_W)-1:0]  pending,
  output logic [ADDR_W:0]           pend_cnt
);
  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;

  logic [DEPTH-1:0] set_mask;
  logic [DEPTH-1:0] clr_mask;
  logic [DEPTH-1:0] pend_nxt;
  logic             inc;
  logic             dec;
  logic [CNT_W-1:0] cnt_nxt;

  // Set wins over clear on the same register: the newer producer is still outstanding.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_en) set_mask[set_idx] = 1'b1;
    if (clr_en) clr_mask[clr_idx] = 1'b1;
    pend_nxt = (pending & ~clr_mask) | set_mask;
    inc      = set_en && !pending[set_idx];
    dec      = clr_en && pending[clr_idx] && !(set_en && (set_idx == clr_idx));
    cnt_nxt  = pend_cnt + CNT_W'(inc) - CNT_W'(dec);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending  <= '0;
      pend_cnt <= '0;
    end else begin
      pending  <= pend_nxt;
      pend_cnt <= cnt_nxt;
    end
  end
endmodule

// File: rtl/regfile_sb.sv
// Two-read/one-write register file with optional zero register, write bypass
// and a pending-write scoreboard driving hazard/stall outputs.
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] rw,
  input  logic [DATA_W-1:0] din,
  input  logic [ADDR_W-1:0] ra,
  input  logic [ADDR_W-1:0] rb,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] b,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] iss_rd,
  output logic              haz_a,
  output logic              haz_b,
  output logic              stall,
  output logic [ADDR_W:0]   pend_cnt
);
  localparam int unsigned       DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZIDX  = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  pending;
  logic              wr_ok;
  logic              iss_ok;
  logic              a_fwd;
  logic              b_fwd;

  assign wr_ok  = we && !(ZERO_REG && (rw == ZIDX));
  assign iss_ok = iss_en && !(ZERO_REG && (iss_rd == ZIDX));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (wr_ok) begin
      regs[rw] <= din;
    end
  end

  sb_bits #(
    .ADDR_W (ADDR_W)
  ) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (iss_ok),
    .set_idx  (iss_rd),
    .clr_en   (wr_ok),
    .clr_idx  (rw),
    .pending  (pending),
    .pend_cnt (pend_cnt)
  );

  // Read muxes with same-cycle forwarding; everything reads as idle during reset.
  always_comb begin
    a     = '0;
    b     = '0;
    haz_a = 1'b0;
    haz_b = 1'b0;
    a_fwd = BYPASS && wr_ok && (rw == ra);
    b_fwd = BYPASS && wr_ok && (rw == rb);
    if (rst_n) begin
      a     = a_fwd ? din : regs[ra];
      b     = b_fwd ? din : regs[rb];
      if (ZERO_REG && (ra == ZIDX)) a = '0;
      if (ZERO_REG && (rb == ZIDX)) b = '0;
      haz_a = pending[ra] && !a_fwd;
      haz_b = pending[rb] && !b_fwd;
    end
    stall = haz_a | haz_b;
  end
endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: two configurations driven in lockstep against an array model.
module tb_regfile_sb;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned N  = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, we, iss_en;
  logic [AW-1:0] rw, ra, rb, iss_rd;
  logic [DW-1:0] din;

  logic [DW-1:0] a0, b0, a1, b1;
  logic          ha0, hb0, st0, ha1, hb1, st1;
  logic [AW:0]   pc0, pc1;

  regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1'b1), .BYPASS(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .we(we), .rw(rw), .din(din), .ra(ra), .rb(rb),
    .a(a0), .b(b0), .iss_en(iss_en), .iss_rd(iss_rd),
    .haz_a(ha0), .haz_b(hb0), .stall(st0), .pend_cnt(pc0)
  );

  regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1'b0), .BYPASS(1'b0)) u_nb (
    .clk(clk), .rst_n(rst_n), .we(we), .rw(rw), .din(din), .ra(ra), .rb(rb),
    .a(a1), .b(b1), .iss_en(iss_en), .iss_rd(iss_rd),
    .haz_a(ha1), .haz_b(hb1), .stall(st1), .pend_cnt(pc1)
  );

  // Reference state per configuration: index 0 = zero reg + bypass, 1 = plain.
  logic [DW-1:0] mregs [2][N];
  bit            mpend [2][N];
  bit            zr [2] = '{1'b1, 1'b0};
  bit            bp [2] = '{1'b1, 1'b0};
  logic [DW-1:0] fill_vals [N];

  int tests = 0;
  int fails = 0;

  function automatic bit wable(int k, int idx);
    return !(zr[k] && idx == 0);
  endfunction

  function automatic logic [DW-1:0] exp_rd(int k, int idx);
    if (!rst_n) return '0;
    if (zr[k] && idx == 0) return '0;
    if (bp[k] && we && wable(k, int'(rw)) && int'(rw) == idx) return din;
    return mregs[k][idx];
  endfunction

  function automatic bit exp_haz(int k, int idx);
    if (!rst_n) return 1'b0;
    return mpend[k][idx] && !(bp[k] && we && int'(rw) == idx);
  endfunction

  function automatic int exp_cnt(int k);
    int c = 0;
    for (int i = 0; i < int'(N); i++) c += int'(mpend[k][i]);
    return c;
  endfunction

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_inst(input int k, input logic [DW-1:0] av, input logic [DW-1:0] bv,
                            input logic ha, input logic hb, input logic st, input logic [AW:0] pc);
    bit eha, ehb;
    eha = exp_haz(k, int'(ra));
    ehb = exp_haz(k, int'(rb));
    check($sformatf("a[%0d] ra=%0d", k, ra), av, exp_rd(k, int'(ra)));
    check($sformatf("b[%0d] rb=%0d", k, rb), bv, exp_rd(k, int'(rb)));
    check($sformatf("haz_a[%0d]", k), DW'(ha), DW'(eha));
    check($sformatf("haz_b[%0d]", k), DW'(hb), DW'(ehb));
    check($sformatf("stall[%0d]", k), DW'(st), DW'(eha | ehb));
    check($sformatf("pend_cnt[%0d]", k), DW'(pc), DW'(exp_cnt(k)));
  endtask

  // Edge effect: reset wipes everything; otherwise the write clears, then an issue re-marks.
  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        for (int i = 0; i < int'(N); i++) begin
          mregs[k][i] = '0;
          mpend[k][i] = 1'b0;
        end
      end else begin
        if (we && wable(k, int'(rw))) begin
          mregs[k][rw] = din;
          mpend[k][rw] = 1'b0;
        end
        if (iss_en && wable(k, int'(iss_rd))) mpend[k][iss_rd] = 1'b1;
      end
    end
  endtask

  task automatic step();
    #1;
    check_inst(0, a0, b0, ha0, hb0, st0, pc0);
    check_inst(1, a1, b1, ha1, hb1, st1, pc1);
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    rst_n = 1'b1; we = 1'b0; iss_en = 1'b0;
    rw = '0; din = '0; iss_rd = '0; ra = '0; rb = '0;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    @(posedge clk);
    model_edge();
    @(negedge clk);

    // Reset clears a previously written register
    idle(); step();
    idle(); we = 1'b1; rw = 5'd5; din = 32'h0000_1234; step();
    idle(); ra = 5'd5; step();
    idle(); rst_n = 1'b0; ra = 5'd5; step();
    idle(); ra = 5'd5; #1;
    check("rst_a", a0, 32'h0);
    check("rst_pend_cnt", DW'(pc0), 32'd0);
    check("rst_stall", DW'(st0), 32'd0);
    step();

    // Zero register ignores writes and issues
    idle(); we = 1'b1; rw = 5'd0; din = 32'hFFFF_FFFF; iss_en = 1'b1; iss_rd = 5'd0; step();
    idle(); ra = 5'd0; #1;
    check("zero_a", a0, 32'h0);
    check("zero_haz_a", DW'(ha0), 32'd0);
    check("zero_pend_cnt", DW'(pc0), 32'd0);
    step();

    // Same-cycle bypass on both ports; no bypass shows stored value
    idle(); we = 1'b1; rw = 5'd7; din = 32'hDEAD_BEEF; ra = 5'd7; rb = 5'd7; #1;
    check("byp_a", a0, 32'hDEAD_BEEF);
    check("byp_b", b0, 32'hDEAD_BEEF);
    check("byp_haz", DW'(ha0 | hb0), 32'd0);
    check("nobyp_a", a1, 32'h0);
    step();

    // Issue then writeback of r3
    idle(); iss_en = 1'b1; iss_rd = 5'd3; step();
    idle(); ra = 5'd3; #1;
    check("iss_haz_a", DW'(ha0), 32'd1);
    check("iss_stall", DW'(st0), 32'd1);
    check("iss_pend_cnt", DW'(pc0), 32'd1);
    step();
    idle(); we = 1'b1; rw = 5'd3; din = 32'h55; ra = 5'd3; #1;
    check("wb_haz_a", DW'(ha0), 32'd0);
    check("wb_a", a0, 32'h55);
    check("wb_nobyp_haz_a", DW'(ha1), 32'd1);
    step();
    idle(); ra = 5'd3; #1;
    check("wb_pend_cnt", DW'(pc0), 32'd0);
    step();

    // Collisions: same-register set/clear, then different-register set/clear
    idle(); iss_en = 1'b1; iss_rd = 5'd4; step();
    idle(); iss_en = 1'b1; iss_rd = 5'd4; we = 1'b1; rw = 5'd4; din = 32'h44; step();
    idle(); ra = 5'd4; #1;
    check("coll_haz_a", DW'(ha0), 32'd1);
    check("coll_pend_cnt", DW'(pc0), 32'd1);
    step();
    idle(); iss_en = 1'b1; iss_rd = 5'd9; step();
    idle(); iss_en = 1'b1; iss_rd = 5'd6; we = 1'b1; rw = 5'd9; din = 32'h99; step();
    idle(); ra = 5'd6; rb = 5'd9; #1;
    check("net0_pend_cnt", DW'(pc0), 32'd2);
    check("net0_haz_a", DW'(ha0), 32'd1);
    check("net0_haz_b", DW'(hb0), 32'd0);
    step();
    idle(); we = 1'b1; rw = 5'd4; din = 32'h4; step();
    idle(); we = 1'b1; rw = 5'd6; din = 32'h6; step();

    // Fill every writable register, then drain
    for (int i = 1; i < int'(N); i++) begin
      idle(); iss_en = 1'b1; iss_rd = AW'(i); step();
    end
    idle(); #1;
    check("fill_pend_cnt", DW'(pc0), 32'd31);
    step();
    for (int i = 1; i < int'(N); i++) begin
      fill_vals[i] = $urandom;
      idle(); we = 1'b1; rw = AW'(i); din = fill_vals[i]; step();
    end
    idle(); #1;
    check("drain_pend_cnt", DW'(pc0), 32'd0);
    step();
    for (int i = 1; i < int'(N); i++) begin
      idle(); ra = AW'(i); rb = AW'(N - 1 - i); #1;
      check($sformatf("drain_a r%0d", i), a0, fill_vals[i]);
      step();
    end

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      rst_n  = ($urandom_range(0, 39) != 0);
      we     = $urandom_range(0, 1) == 1;
      iss_en = $urandom_range(0, 9) < 4;
      rw     = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7)) : AW'($urandom);
      iss_rd = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7)) : AW'($urandom);
      ra     = ($urandom_range(0, 2) == 0) ? rw : AW'($urandom_range(0, 7));
      rb     = ($urandom_range(0, 2) == 0) ? iss_rd : AW'($urandom);
      din    = $urandom;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
